d_ff_sync: RTL and testbench
============================

# d_ff_sync

Parameterised D-type register with clock enable, asynchronous active-low reset and an optional reset-deassertion synchronizer. It is the basic storage element for pipeline and control registers across the design. Each `d` bit is captured on the rising edge of `clk`. An inverted output is provided, along with a per-bit change flag for downstream edge logic.

## Interface
- `WIDTH`, 1: number of data bits (≥1).
- `RESET_VALUE`, '0: value loaded into `q` while reset is active (WIDTH bits).
- `clk`  input  1  rising-edge clock; single clock domain.
- `rstn`  input  1  asynchronous, active-low reset.
- `en`  input  1  capture enable; when 0, `q` holds.
- `d`  input  WIDTH  data to capture.
- `q`  output  WIDTH  registered data.
- `q_n`  output  WIDTH  bitwise inverse of `q`, combinational from `q`.
- `chg`  output  WIDTH  registered flag; bit i = 1 for one cycle after `q[i]` changed on the last capture.

## Operation
- Reset (`rstn`=0):
  - `q` = RESET_VALUE immediately, with no clock needed.
  - `chg` = 0.
  - `q_n` = ~RESET_VALUE.
- While reset is held, `d` and `en` are ignored.
- Normal operation, on each rising `clk` edge:
  - If `en`=1: `q` ← `d`; `chg` ← `q_old ^ d`.
  - If `en`=0: `q` holds; `chg` ← 0.
- `chg` is never set by reset entry or reset exit.
- Capturing `d` equal to the current `q` gives `chg`=0.
- There is no width arithmetic; all operations are bitwise on WIDTH bits.

## Timing
- Latency is one cycle: `d` present before rising edge N appears on `q` just after edge N.
- Setup and hold apply to `d` and `en` relative to the rising edge.
- `rstn` assertion is asynchronous and overrides everything in the same instant, including mid-cycle.
- Without the synchronizer, `rstn` deassertion takes effect at the next rising edge: that edge captures `d` if `en`=1.
- With the synchronizer, see Configuration.
- If `rstn` rises coincident with a clock edge, that edge does not capture; the following edge is the first capture.

## Configuration
- Macro: `D_FF_SYNC_RST_SYNC_EN`.
- Defined:
  - `rstn` passes through a 2-flop synchronizer before driving the register.
  - Assertion remains asynchronous (both sync flops clear immediately).
  - Deassertion is released after the 2nd rising edge following `rstn`=1.
  - The first capture happens on the 3rd rising edge.
- Undefined:
  - `rstn` drives the register reset directly.
  - No synchronizer logic is compiled in.
  - The first capture is on the 1st rising edge after `rstn`=1.

## Structure
- Shared package `d_ff_sync_pkg`:
  - `localparam int RST_SYNC_STAGES = 2`.
  - Default WIDTH constant.
- Sub-module `rst_sync`:
  - 2-flop async-assert / sync-deassert reset synchronizer.
  - Ports: `clk`, `rstn_in`, `rstn_out`.
  - Instantiated only under `D_FF_SYNC_RST_SYNC_EN`.
- Top level holds the `q` and `chg` registers and the `q_n` inversion.

## Test plan
All scenarios use WIDTH=1, RESET_VALUE=0, 10 ns clock, macro undefined unless stated.
- Reset hold: `rstn`=0, `d`=1, `en`=1 for 3 edges → `q`=0, `q_n`=1, `chg`=0 throughout.
- Capture: release `rstn`; `d`=1 before the next edge → `q`=1 after that edge; `chg`=1 for exactly one cycle, then 0. Set `d`=0 → `q`=0 next edge, `chg`=1.
- Mid-cycle async reset: `q`=1; drop `rstn` 3 ns after an edge → `q`=0 within that cycle, before the next edge.
- Enable hold: `q`=1, `en`=0, toggle `d` 0/1 for 4 edges → `q` stays 1, `chg`=0.
- WIDTH=8, RESET_VALUE=8'hA5: reset → `q`=8'hA5; load `d`=8'h5A → `q`=8'h5A, `chg`=8'hFF.
- Macro defined: release `rstn` and hold `d`=1 → `q` still 0 after edges 1 and 2, `q`=1 after edge 3. Re-assert `rstn` → `q`=0 immediately.

Source files
------------

// File: rtl/d_ff_sync_pkg.sv
// Shared constants for the d_ff_sync register and its reset synchronizer.
package d_ff_sync_pkg;

    // Number of flops in the reset-deassertion synchronizer.
    localparam int RST_SYNC_STAGES = 2;

    // Data width used when an instance does not override WIDTH.
    localparam int DEFAULT_WIDTH = 1;

endpackage : d_ff_sync_pkg

// File: rtl/d_ff_sync_rst_sync.sv
// Reset synchronizer: asynchronous assertion, synchronous deassertion.
// rstn_out goes low as soon as rstn_in goes low, and goes high only after
// RST_SYNC_STAGES rising edges of clk have seen rstn_in high.
module rst_sync
    import d_ff_sync_pkg::*;
(
    input  logic clk,
    input  logic rstn_in,
    output logic rstn_out
);

    logic [RST_SYNC_STAGES-1:0] sync_q;

    // Shift a '1' through the chain once reset is released; clear all stages at once on assertion.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[RST_SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rstn_out = sync_q[RST_SYNC_STAGES-1];

endmodule : rst_sync

// File: rtl/d_ff_sync.sv
// Parameterised D register with clock enable, asynchronous active-low reset,
// inverted output and a registered per-bit change flag.
// Optional feature: define D_FF_SYNC_RST_SYNC_EN to route rstn through a
// 2-flop reset synchronizer (async assert, sync deassert) before the register.
module d_ff_sync
    import d_ff_sync_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] chg
);

    logic             rst_int_n;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] chg_q;
    logic [WIDTH-1:0] chg_d;

`ifdef D_FF_SYNC_RST_SYNC_EN
    // Deassertion is delayed by the synchronizer; assertion still propagates immediately.
    rst_sync u_rst_sync (
        .clk      (clk),
        .rstn_in  (rstn),
        .rstn_out (rst_int_n)
    );
`else
    assign rst_int_n = rstn;
`endif

    // Next state: load d when enabled and flag the bits that flip; otherwise hold with no flags.
    always_comb begin
        q_d   = q_q;
        chg_d = '0;
        if (en) begin
            q_d   = d;
            chg_d = q_q ^ d;
        end
    end

    // Storage for data and change flags; reset forces the reset value and clears flags.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            q_q   <= RESET_VALUE;
            chg_q <= '0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    assign q   = q_q;
    assign q_n = ~q_q;
    assign chg = chg_q;

endmodule : d_ff_sync

// File: tb/tb_d_ff_sync.sv
// Bench for d_ff_sync: a 1-bit instance (reset value 0) and an 8-bit instance
// (reset value 8'hA5) share clock, reset and enable, and are checked against
// a cycle-level reference model after every rising edge.
module tb_d_ff_sync;

    localparam logic [7:0] RV8 = 8'hA5;
`ifdef D_FF_SYNC_RST_SYNC_EN
    localparam int REL_LAT = 2;
`else
    localparam int REL_LAT = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rstn;
    logic en;
    logic [0:0] d1;
    logic [7:0] d8;
    logic [0:0] q1, q_n1, chg1;
    logic [7:0] q8, q_n8, chg8;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    d_ff_sync #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .d    (d1),
        .q    (q1),
        .q_n  (q_n1),
        .chg  (chg1)
    );

    d_ff_sync #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .d    (d8),
        .q    (q8),
        .q_n  (q_n8),
        .chg  (chg8)
    );

    // ---------------- reference model ----------------
    logic [0:0] m_q1, m_chg1;
    logic [7:0] m_q8, m_chg8;
    int         rel_edges;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q1      = 1'b0;
        m_chg1    = '0;
        m_q8      = RV8;
        m_chg8    = '0;
        rel_edges = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q1"},    {7'd0, q1},    {7'd0, m_q1});
        check({tag, ".qn1"},   {7'd0, q_n1},  {7'd0, ~m_q1});
        check({tag, ".chg1"},  {7'd0, chg1},  {7'd0, m_chg1});
        check({tag, ".q8"},    q8,    m_q8);
        check({tag, ".qn8"},   q_n8,  ~m_q8);
        check({tag, ".chg8"},  chg8,  m_chg8);
    endtask

    // One rising edge: inputs set before it are what the model applies,
    // then outputs are checked 1 ns after the edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else if (rel_edges < REL_LAT) begin
            rel_edges++;
            m_chg1 = '0;
            m_chg8 = '0;
        end else if (en) begin
            m_chg1 = m_q1 ^ d1;
            m_q1   = d1;
            m_chg8 = m_q8 ^ d8;
            m_q8   = d8;
        end else begin
            m_chg1 = '0;
            m_chg8 = '0;
        end
        #1;
        check_all(tag);
    endtask

    // Called 1 ns after an edge: drop rstn 3 ns after the edge and expect
    // the outputs to reset before the next edge arrives.
    task automatic async_drop(input string tag);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all(tag);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rstn = 1'b0;
        en   = 1'b1;
        d1   = 1'b1;
        d8   = 8'h5A;
        model_reset();

        // Reset hold: d/en ignored
        for (int i = 0; i < 3; i++) step("rst_hold");

        // Capture after release
        rstn = 1'b1;
        d1 = 1'b1; d8 = 8'h5A;
        for (int i = 0; i < REL_LAT; i++) step("rel_wait");
        step("cap1");
        step("cap1_hold");
        d1 = 1'b0; d8 = 8'h3C;
        step("cap0");

        // Mid-cycle asynchronous reset
        d1 = 1'b1; d8 = 8'hFF;
        step("pre_arst");
        async_drop("arst");
        step("arst_edge");
        rstn = 1'b1;
        for (int i = 0; i < REL_LAT; i++) step("rel_wait2");
        step("reload");

        // Enable hold while d toggles
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d1 = i[0];
            d8 = 8'(i * 8'h11);
            step("en_hold");
        end

        // Same-value capture gives no change flags
        en = 1'b1;
        d1 = m_q1; d8 = m_q8;
        step("same_val");

        // Randomized traffic with occasional async resets
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 3) != 0);
            d1 = 1'($urandom_range(0, 1));
            d8 = 8'($urandom_range(0, 255));
            if (!rstn && $urandom_range(0, 2) == 0) rstn = 1'b1;
            step("rand");
            if (rstn && $urandom_range(0, 24) == 0) async_drop("rand_arst");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_d_ff_sync
